baud_detect: RTL

Auto-baud detector: measures the low period of an incoming UART start bit and returns the `div` value that makes `clk_div` reproduce that bit rate. It is the inverse of `clk_div`: `clk_div` turns a divisor into a bit clock, and this block turns an observed bit time into a divisor. It sits between the FPGA `rx` pin and the UART divisor register. The host sends 0x55 ('U'), so the start bit is exactly one bit period long.

---
 rtl/baud_detect_pkg.sv | 11 +
 rtl/bit_sync.sv | 18 +
 rtl/baud_detect.sv | 78 +++++++
 3 files changed

// File: rtl/baud_detect_pkg.sv
// Shared types and constants for the auto-baud detector.
package baud_detect_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    WAIT_FALL = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  localparam int MIN_PERIOD = 4;
endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 (idle line).
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '1;
    else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
  end

  assign q = sync_pipe[SYNC_STAGES-1];
endmodule

// File: rtl/baud_detect.sv
// Auto-baud detector: times the start-bit low period and converts it to a clk_div divisor.
module baud_detect
  import baud_detect_pkg::*;
#(
  parameter int CLK_CNT_WIDTH = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     rx,
  output logic [CLK_CNT_WIDTH-1:0] div,
  output logic                     div_valid,
  output logic                     err,
  output logic                     busy
);
  localparam int CW = CLK_CNT_WIDTH + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rx_s;
  logic [CW:0]   half;
  logic [CW:0]   div_next;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Half period rounded to nearest (ties up); one extra bit so T+1 cannot wrap.
  assign half     = ({1'b0, cnt} + (CW+1)'(1)) >> 1;
  assign div_next = half - (CW+1)'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div       <= '0;
      div_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      div_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE:      if (start) state <= WAIT_IDLE;
        WAIT_IDLE: if (rx_s)  state <= WAIT_FALL;
        WAIT_FALL: begin
          if (!rx_s) begin
            cnt   <= CW'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (!rx_s) begin
            if (&cnt) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            if (cnt < CW'(MIN_PERIOD)) begin
              err <= 1'b1;
            end else begin
              div       <= div_next[CLK_CNT_WIDTH-1:0];
              div_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
